// File: rtl/nh_lcd_defines.sv
// Shared owner codes, FSM states and pad-bus bundle for the LCD bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package nh_lcd_defines;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CMD  = 2'd1,
        OWN_DAT  = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_CMD = 2'd1,
        ST_GNT_DAT = 2'd2,
        ST_TURN    = 2'd3
    } state_e;

    typedef struct packed {
        logic       cmd_mode;
        logic       write;
        logic       read;
        logic       data_out_en;
        logic [7:0] data_out;
    } bus_t;

    localparam logic IDLE_CMD_MODE = 1'b1;

    // Parked pad value; write data is held so the pins do not toggle needlessly.
    function automatic bus_t bus_idle(input logic [7:0] hold_dat);
        bus_t b;
        b.cmd_mode    = IDLE_CMD_MODE;
        b.write       = 1'b0;
        b.read        = 1'b0;
        b.data_out_en = 1'b0;
        b.data_out    = hold_dat;
        return b;
    endfunction

endpackage

// File: rtl/nh_lcd_bus_arbiter_if.sv
// Signal bundle between the two LCD masters, the arbiter and the pad logic.
// Latency: n/a. Backpressure: req/gnt handshake, req held for a whole transaction.
// slave = arbiter side, master = environment (masters + pads) side.
interface nh_lcd_bus_arbiter_if;
    logic       i_cmd_req;
    logic       o_cmd_gnt;
    logic       i_cmd_cmd_mode;
    logic       i_cmd_write;
    logic       i_cmd_read;
    logic       i_cmd_data_out_en;
    logic [7:0] i_cmd_data_out;
    logic [7:0] o_cmd_data_in;

    logic       i_dat_req;
    logic       o_dat_gnt;
    logic       i_dat_cmd_mode;
    logic       i_dat_write;
    logic       i_dat_read;
    logic       i_dat_data_out_en;
    logic [7:0] i_dat_data_out;
    logic [7:0] o_dat_data_in;

    logic       o_cmd_mode;
    logic [7:0] o_data_out;
    logic [7:0] i_data_in;
    logic       o_write;
    logic       o_read;
    logic       o_data_out_en;
    logic [1:0] o_owner;
    logic       o_violation;

    modport slave (
        input  i_cmd_req, i_cmd_cmd_mode, i_cmd_write, i_cmd_read,
               i_cmd_data_out_en, i_cmd_data_out,
               i_dat_req, i_dat_cmd_mode, i_dat_write, i_dat_read,
               i_dat_data_out_en, i_dat_data_out, i_data_in,
        output o_cmd_gnt, o_cmd_data_in, o_dat_gnt, o_dat_data_in,
               o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en,
               o_owner, o_violation
    );

    modport master (
        output i_cmd_req, i_cmd_cmd_mode, i_cmd_write, i_cmd_read,
               i_cmd_data_out_en, i_cmd_data_out,
               i_dat_req, i_dat_cmd_mode, i_dat_write, i_dat_read,
               i_dat_data_out_en, i_dat_data_out, i_data_in,
        input  o_cmd_gnt, o_cmd_data_in, o_dat_gnt, o_dat_data_in,
               o_cmd_mode, o_data_out, o_write, o_read, o_data_out_en,
               o_owner, o_violation
    );
endinterface

// File: rtl/nh_lcd_turn_timer.sv
// Turnaround down-counter: load a count, decrement while enabled, done at zero.
// Latency: done is registered state, valid the cycle after load.
// Backpressure: none.
module nh_lcd_turn_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 4'd0);
endmodule

// File: rtl/nh_lcd_bus_arbiter.sv
// Round-robin owner of the 8080 LCD bus between CMD and DAT with registered pad mux.
// Latency: req->gnt 2 edges, master inputs->pad 1 cycle, pad read data->master 1 cycle.
// Backpressure: req held off during ownership and PARK_CYCLES turnaround; no preemption.
module nh_lcd_bus_arbiter
    import nh_lcd_defines::*;
#(
    parameter int unsigned PARK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nh_lcd_bus_arbiter_if.slave  bus
);
    localparam bit         PARK_EN   = (PARK_CYCLES != 0);
    localparam logic [3:0] PARK_LOAD = PARK_EN ? 4'(PARK_CYCLES - 1) : 4'd0;

    state_e     state_q, state_d;
    owner_e     last_owner_q, last_owner_d;
    owner_e     owner_q, owner_d;
    owner_e     rd_own_q, rd_own_d;
    bus_t       pad_q, pad_d;
    logic       vio_q, vio_d;
    logic [7:0] cmd_din_q, cmd_din_d;
    logic [7:0] dat_din_q, dat_din_d;
    logic       tmr_load, tmr_en, tmr_done;
    bus_t       cmd_bus, dat_bus;

    nh_lcd_turn_timer u_turn_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (PARK_LOAD),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd_req && bus.i_dat_req) begin
                    state_d = (last_owner_q == OWN_CMD) ? ST_GNT_DAT : ST_GNT_CMD;
                end else if (bus.i_cmd_req) begin
                    state_d = ST_GNT_CMD;
                end else if (bus.i_dat_req) begin
                    state_d = ST_GNT_DAT;
                end
            end
            ST_GNT_CMD: begin
                if (!bus.i_cmd_req) begin
                    last_owner_d = OWN_CMD;
                    tmr_load     = PARK_EN;
                    state_d      = PARK_EN ? ST_TURN : ST_IDLE;
                end
            end
            ST_GNT_DAT: begin
                if (!bus.i_dat_req) begin
                    last_owner_d = OWN_DAT;
                    tmr_load     = PARK_EN;
                    state_d      = PARK_EN ? ST_TURN : ST_IDLE;
                end
            end
            ST_TURN: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ownership (and so gnt) lags the state by one edge; a released owner drops at once.
    always_comb begin
        owner_d = OWN_NONE;
        if ((state_q == ST_GNT_CMD) && bus.i_cmd_req) begin
            owner_d = OWN_CMD;
        end else if ((state_q == ST_GNT_DAT) && bus.i_dat_req) begin
            owner_d = OWN_DAT;
        end
    end

    // Strobes only pass for the master that already holds the bus.
    always_comb begin
        cmd_bus.cmd_mode    = bus.i_cmd_cmd_mode;
        cmd_bus.write       = bus.i_cmd_write & (owner_q == OWN_CMD);
        cmd_bus.read        = bus.i_cmd_read  & (owner_q == OWN_CMD);
        cmd_bus.data_out_en = bus.i_cmd_data_out_en;
        cmd_bus.data_out    = bus.i_cmd_data_out;

        dat_bus.cmd_mode    = bus.i_dat_cmd_mode;
        dat_bus.write       = bus.i_dat_write & (owner_q == OWN_DAT);
        dat_bus.read        = bus.i_dat_read  & (owner_q == OWN_DAT);
        dat_bus.data_out_en = bus.i_dat_data_out_en;
        dat_bus.data_out    = bus.i_dat_data_out;

        case (owner_d)
            OWN_CMD: pad_d = cmd_bus;
            OWN_DAT: pad_d = dat_bus;
            default: pad_d = bus_idle(pad_q.data_out);
        endcase

        vio_d = ((bus.i_cmd_write | bus.i_cmd_read) && (owner_q != OWN_CMD)) ||
                ((bus.i_dat_write | bus.i_dat_read) && (owner_q != OWN_DAT));

        // Pad read data arrives the cycle after the registered read strobe.
        rd_own_d  = pad_q.read ? owner_q : OWN_NONE;
        cmd_din_d = (rd_own_q == OWN_CMD) ? bus.i_data_in : cmd_din_q;
        dat_din_d = (rd_own_q == OWN_DAT) ? bus.i_data_in : dat_din_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_DAT;
            owner_q      <= OWN_NONE;
            rd_own_q     <= OWN_NONE;
            pad_q        <= bus_idle(8'h00);
            vio_q        <= 1'b0;
            cmd_din_q    <= 8'h00;
            dat_din_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            rd_own_q     <= rd_own_d;
            pad_q        <= pad_d;
            vio_q        <= vio_d;
            cmd_din_q    <= cmd_din_d;
            dat_din_q    <= dat_din_d;
        end
    end

    assign bus.o_cmd_gnt     = (owner_q == OWN_CMD);
    assign bus.o_dat_gnt     = (owner_q == OWN_DAT);
    assign bus.o_owner       = owner_q;
    assign bus.o_cmd_mode    = pad_q.cmd_mode;
    assign bus.o_write       = pad_q.write;
    assign bus.o_read        = pad_q.read;
    assign bus.o_data_out_en = pad_q.data_out_en;
    assign bus.o_data_out    = pad_q.data_out;
    assign bus.o_violation   = vio_q;
    assign bus.o_cmd_data_in = cmd_din_q;
    assign bus.o_dat_data_in = dat_din_q;
endmodule

// File: tb/tb_nh_lcd_bus_arbiter.sv
// Directed bench for nh_lcd_bus_arbiter: stimulus pushes expected pad writes,
// violations, read returns and grants; a negedge monitor pops and compares them.
module tb_nh_lcd_bus_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nh_lcd_bus_arbiter_if bus();

    nh_lcd_bus_arbiter #(.PARK_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // a/b: expected values, cyc: cycle index the event must appear in (-1 = any)
    typedef struct {
        int a;
        int b;
        int cyc;
    } exp_t;

    exp_t wr_q[$];
    exp_t vio_q[$];
    exp_t rd_q[$];
    exp_t gnt_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic have_item(input string name, input int sz, output bit ok);
        checks++;
        ok = (sz > 0);
        if (!ok) begin
            failures++;
            $display("FAIL %s: got unexpected event, want none (cycle %0d)", name, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_cmd_req = 1'b0; bus.i_cmd_cmd_mode = 1'b1; bus.i_cmd_write = 1'b0;
        bus.i_cmd_read = 1'b0; bus.i_cmd_data_out_en = 1'b0; bus.i_cmd_data_out = 8'h00;
        bus.i_dat_req = 1'b0; bus.i_dat_cmd_mode = 1'b1; bus.i_dat_write = 1'b0;
        bus.i_dat_read = 1'b0; bus.i_dat_data_out_en = 1'b0; bus.i_dat_data_out = 8'h00;
        bus.i_data_in = 8'h00;
    endtask

    task automatic wait_gnt(input bit dat);
        int n = 0;
        while (!(dat ? bus.o_dat_gnt : bus.o_cmd_gnt) && n < 20) begin
            tick();
            n++;
        end
        chk(dat ? "dat_gnt_timeout" : "cmd_gnt_timeout", int'(n < 20), 1);
    endtask

    // Monitor
    bit         prev_cg  = 1'b0;
    bit         prev_dg  = 1'b0;
    logic [7:0] prev_cdi = 8'h00;
    logic [7:0] prev_ddi = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (bus.o_write) begin
            have_item("unexpected_pad_write", wr_q.size(), ok);
            if (ok) begin
                e = wr_q.pop_front();
                chk("pad_wr_data", int'(bus.o_data_out), e.a);
                chk("pad_wr_mode", int'(bus.o_cmd_mode), e.b);
                chk("pad_wr_cycle", cyc, e.cyc);
            end
        end
        if (bus.o_violation) begin
            have_item("unexpected_violation", vio_q.size(), ok);
            if (ok) begin
                e = vio_q.pop_front();
                chk("violation_cycle", cyc, e.cyc);
            end
        end
        if (bus.o_cmd_data_in !== prev_cdi || bus.o_dat_data_in !== prev_ddi) begin
            have_item("unexpected_data_in_change", rd_q.size(), ok);
            if (ok) begin
                e = rd_q.pop_front();
                chk("cmd_data_in", int'(bus.o_cmd_data_in), e.a);
                chk("dat_data_in", int'(bus.o_dat_data_in), e.b);
                if (e.cyc >= 0) chk("data_in_cycle", cyc, e.cyc);
            end
        end
        if ((bus.o_cmd_gnt && !prev_cg) || (bus.o_dat_gnt && !prev_dg)) begin
            have_item("unexpected_grant", gnt_q.size(), ok);
            if (ok) begin
                e = gnt_q.pop_front();
                chk("gnt_owner", int'(bus.o_owner), e.a);
                chk("gnt_who", int'({bus.o_dat_gnt, bus.o_cmd_gnt}), e.a);
                chk("gnt_cycle", cyc, e.cyc);
            end
        end
        prev_cg  = bus.o_cmd_gnt;
        prev_dg  = bus.o_dat_gnt;
        prev_cdi = bus.o_cmd_data_in;
        prev_ddi = bus.o_dat_data_in;
    end

    initial begin
        idle_inputs();
        #2 rst_n = 1'b0;
        repeat (3) tick();

        chk("rst_cmd_gnt", int'(bus.o_cmd_gnt), 0);
        chk("rst_dat_gnt", int'(bus.o_dat_gnt), 0);
        chk("rst_owner", int'(bus.o_owner), 0);
        chk("rst_cmd_mode", int'(bus.o_cmd_mode), 1);
        chk("rst_write", int'(bus.o_write), 0);
        chk("rst_read", int'(bus.o_read), 0);
        chk("rst_oe", int'(bus.o_data_out_en), 0);
        chk("rst_data_out", int'(bus.o_data_out), 0);
        chk("rst_violation", int'(bus.o_violation), 0);

        rst_n = 1'b1;
        tick();

        // Both request together after reset: CMD wins, grant 2 edges later.
        bus.i_cmd_req = 1'b1;
        bus.i_dat_req = 1'b1;
        gnt_q.push_back('{1, 0, cyc + 2});
        wait_gnt(1'b0);
        chk("dat_gnt_while_cmd", int'(bus.o_dat_gnt), 0);

        // CMD write 0x2C reaches the pad one cycle later.
        bus.i_cmd_cmd_mode = 1'b0; bus.i_cmd_write = 1'b1;
        bus.i_cmd_data_out_en = 1'b1; bus.i_cmd_data_out = 8'h2C;
        wr_q.push_back('{'h2C, 0, cyc + 1});
        tick();
        bus.i_cmd_write = 1'b0; bus.i_cmd_data_out_en = 1'b0; bus.i_cmd_cmd_mode = 1'b1;
        tick();

        // CMD read: only data on the cycle after the registered read is captured.
        bus.i_cmd_read = 1'b1;
        tick();
        chk("pad_read", int'(bus.o_read), 1);
        bus.i_cmd_read = 1'b0;
        bus.i_data_in  = 8'hEE;
        tick();
        bus.i_data_in = 8'h5A;
        rd_q.push_back('{'h5A, 0, cyc + 1});
        tick();
        bus.i_data_in = 8'h00;
        tick();
        chk("dat_data_in_kept", int'(bus.o_dat_data_in), 0);

        // Release with DAT waiting: PARK_CYCLES turnaround + idle + grant edge.
        bus.i_cmd_req = 1'b0;
        gnt_q.push_back('{2, 0, cyc + 5});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_cmd_gnt", int'(bus.o_cmd_gnt), 0);
            chk("gap_dat_gnt", int'(bus.o_dat_gnt), 0);
            chk("gap_owner", int'(bus.o_owner), 0);
            chk("gap_oe", int'(bus.o_data_out_en), 0);
        end
        wait_gnt(1'b1);

        // DAT writes 0xA5 while CMD illegally strobes write.
        bus.i_dat_cmd_mode = 1'b1; bus.i_dat_write = 1'b1;
        bus.i_dat_data_out_en = 1'b1; bus.i_dat_data_out = 8'hA5;
        bus.i_cmd_write = 1'b1;
        wr_q.push_back('{'hA5, 1, cyc + 1});
        vio_q.push_back('{0, 0, cyc + 1});
        tick();
        bus.i_dat_write = 1'b0; bus.i_cmd_write = 1'b0;
        tick();

        // Reset in the middle of a DAT burst.
        bus.i_dat_write = 1'b1; bus.i_dat_data_out = 8'h33;
        wr_q.push_back('{'h33, 1, cyc + 1});
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        rd_q.push_back('{0, 0, -1});
        #1;
        chk("mid_rst_cmd_gnt", int'(bus.o_cmd_gnt), 0);
        chk("mid_rst_dat_gnt", int'(bus.o_dat_gnt), 0);
        chk("mid_rst_write", int'(bus.o_write), 0);
        chk("mid_rst_oe", int'(bus.o_data_out_en), 0);
        chk("mid_rst_owner", int'(bus.o_owner), 0);
        bus.i_dat_write = 1'b0; bus.i_dat_data_out_en = 1'b0;
        bus.i_cmd_req = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        gnt_q.push_back('{1, 0, cyc + 2});
        wait_gnt(1'b0);

        bus.i_cmd_req = 1'b0;
        bus.i_dat_req = 1'b0;
        repeat (8) tick();

        chk("left_wr", wr_q.size(), 0);
        chk("left_vio", vio_q.size(), 0);
        chk("left_rd", rd_q.size(), 0);
        chk("left_gnt", gnt_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
